fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded at reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), giving the bubble encoding.
REQ-003 The block SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 The block SHALL have port pc, output, 32: fetch address driven to the instruction memory.
REQ-006 The block SHALL have port imem_stall, output, 1: hold request to the instruction memory, equal to stall_in AND NOT branch_taken.
REQ-007 The block SHALL have port instr, input, 32: instruction word returned combinationally by the instruction memory for the current pc.
REQ-008 The block SHALL have port stall_in, input, 1: hazard-unit request to freeze the PC and the IF/ID register.
REQ-009 The block SHALL have port branch_taken, input, 1: redirect request from the execute stage.
REQ-010 The block SHALL have port branch_target, input, 32: redirect address, valid while branch_taken is high.
REQ-011 The block SHALL have port if_id_pc, output, 32: PC of the instruction held in IF/ID.
REQ-012 The block SHALL have port if_id_instr, output, 32: instruction held in IF/ID.
REQ-013 The block SHALL have port if_id_valid, output, 1: IF/ID holds a real instruction, not a bubble.
REQ-014 The block SHALL have port misalign_err, output, 1: one-cycle pulse when branch_target[1:0] is nonzero.
REQ-015 The block SHALL have port fetch_count, output, 32: count of instructions accepted into IF/ID.

Function
REQ-016 The FSM SHALL have states BOOT, RUN, HOLD and REDIRECT.
REQ-017 BOOT SHALL last exactly one cycle after reset release, then go to RUN; in BOOT IF/ID SHALL hold a bubble and pc SHALL stay at RESET_PC.
REQ-018 In RUN with no stall and no branch, each cycle pc SHALL advance by 4 (mod 2^32) and IF/ID SHALL capture {pc, instr} with if_id_valid=1.
REQ-019 With stall_in=1 and branch_taken=0, the FSM SHALL enter HOLD, and pc, if_id_pc, if_id_instr, if_id_valid and fetch_count SHALL be unchanged that cycle.
REQ-020 HOLD SHALL return to RUN on the first cycle with stall_in=0; that cycle SHALL behave as RUN, with no instruction lost or duplicated.
REQ-021 branch_taken=1 in cycle N SHALL set pc to {branch_target[31:2],2'b00} at cycle N+1, load a bubble (NOP_INSTR, valid=0, if_id_pc unchanged) into IF/ID, and enter REDIRECT.
REQ-022 REDIRECT SHALL last one cycle and behave as RUN; the target instruction SHALL appear in IF/ID at cycle N+2.
REQ-023 branch_taken SHALL take priority over stall_in in any state, including BOOT and HOLD.
REQ-024 A branch arriving during REDIRECT SHALL restart redirect to the new target.
REQ-025 pc+4 from 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 with no error.
REQ-026 fetch_count SHALL increment by 1 on every cycle IF/ID loads with valid=1, and SHALL wrap at 2^32.
REQ-027 misalign_err SHALL be registered and high in cycle N+1 only, for branch_taken=1 with branch_target[1:0]!=0 in cycle N.

Reset
REQ-028 With rst_n=0 at a clock edge, the block SHALL set state=BOOT, pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, misalign_err=0, fetch_count=0.
REQ-029 Reset SHALL override stall_in and branch_taken, including reset asserted mid-redirect or mid-hold.

Structure
REQ-030 The FSM state enumeration, NOP_INSTR and the PC increment constant (4) SHALL be in the shared cpu package.
REQ-031 The IF/ID register SHALL be a sub-module named if_id_reg, with enable and flush inputs; PC and FSM logic SHALL stay in fetch_unit.

Verification
REQ-032 Reset release, no stall/branch, mem[0..2]=A,B,C -> IF/ID shows (0,A),(4,B),(8,C) on cycles 2,3,4; fetch_count=3.
REQ-033 stall_in high 3 cycles while IF/ID=(4,B) -> IF/ID and pc=8 frozen 3 cycles, then (8,C) follows.
REQ-034 branch_taken with target 0x40 at cycle N -> pc=0x40 at N+1, if_id_valid=0 at N+1, IF/ID=(0x40,mem[16]) at N+2.
REQ-035 branch_taken and stall_in together, target 0x20 -> redirect occurs and imem_stall=0.
REQ-036 Branch target 0x42 -> pc=0x40, misalign_err high exactly one cycle.
REQ-037 Force pc to 0xFFFF_FFFC -> next pc=0x0; rst_n low during REDIRECT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: fetch FSM states, bubble encoding, PC step.
package cpu_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHold,
    StRedirect
  } fetch_state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  // Instructions are word aligned; low address bits of a redirect are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush inserts a bubble but keeps the held PC;
// flush wins over enable.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        valid
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= 32'h0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (en) begin
      pc_q    <= pc_in;
      instr_q <= instr_in;
      valid_q <= 1'b1;
    end
  end

  assign pc    = pc_q;
  assign instr = instr_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, stall/redirect FSM and IF/ID register control.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic        imem_stall,
  input  logic [31:0] instr,
  input  logic        stall_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  count_q;
  logic         misalign_q;

  logic ifid_load;
  logic ifid_flush;

  // Branch beats stall; BOOT never fetches, so it keeps the reset bubble.
  always_comb begin
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (branch_taken) begin
      ifid_flush = 1'b1;
    end else if (state_q == StBoot) begin
      ifid_flush = 1'b1;
    end else if (!stall_in) begin
      ifid_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      count_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else if (branch_taken) begin
      state_q    <= StRedirect;
      pc_q       <= word_align(branch_target);
      misalign_q <= is_misaligned(branch_target);
    end else begin
      misalign_q <= 1'b0;
      unique case (state_q)
        StBoot: state_q <= StRun;
        StRun, StHold, StRedirect: begin
          if (stall_in) begin
            state_q <= StHold;
          end else begin
            state_q <= StRun;
            pc_q    <= pc_q + PC_INC;
            count_q <= count_q + 32'd1;
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  if_id_reg #(
    .NOP(NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ifid_load),
    .flush   (ifid_flush),
    .pc_in   (pc_q),
    .instr_in(instr),
    .pc      (if_id_pc),
    .instr   (if_id_instr),
    .valid   (if_id_valid)
  );

  assign pc           = pc_q;
  assign imem_stall   = stall_in & ~branch_taken;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed steps push expected post-edge state,
// a monitor pops and compares one entry per clock.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        imem_stall;
  logic [31:0] instr;
  logic        stall_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] iinstr;
    logic        ivalid;
    logic        mis;
    logic [31:0] cnt;
    logic        istall;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  bit   stim_done;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .imem_stall   (imem_stall),
    .instr        (instr),
    .stall_in     (stall_in),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  // Instruction memory: word at address a is 0x1000_0000 + a (mod 2^32).
  assign instr = 32'h1000_0000 + pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string vec, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s.%s: got %h, expected %h", vec, field, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, sampled after the edge settles.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      chk(e.name, "pc", pc, e.pc);
      chk(e.name, "if_id_pc", if_id_pc, e.ipc);
      chk(e.name, "if_id_instr", if_id_instr, e.iinstr);
      chk(e.name, "if_id_valid", {31'h0, if_id_valid}, {31'h0, e.ivalid});
      chk(e.name, "misalign_err", {31'h0, misalign_err}, {31'h0, e.mis});
      chk(e.name, "fetch_count", fetch_count, e.cnt);
      chk(e.name, "imem_stall", {31'h0, imem_stall}, {31'h0, e.istall});
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the expected outcome.
  task automatic step(input string name, input logic rn, input logic st, input logic br,
                      input logic [31:0] tgt, input logic [31:0] e_pc,
                      input logic [31:0] e_ipc, input logic [31:0] e_instr,
                      input logic e_valid, input logic e_mis, input logic [31:0] e_cnt,
                      input logic e_istall);
    exp_t e;
    @(negedge clk);
    rst_n         = rn;
    stall_in      = st;
    branch_taken  = br;
    branch_target = tgt;
    e.name   = name;
    e.pc     = e_pc;
    e.ipc    = e_ipc;
    e.iinstr = e_instr;
    e.ivalid = e_valid;
    e.mis    = e_mis;
    e.cnt    = e_cnt;
    e.istall = e_istall;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    stim_done   = 1'b0;
    rst_n = 1'b0; stall_in = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    @(posedge clk);
    //      name         rn st br target        pc            ipc           instr         v  m  cnt  is
    step("reset",        0, 0, 0, 32'h0,        32'h0,        32'h0,        NOP,          0, 0, 0,  0);
    step("boot",         1, 0, 0, 32'h0,        32'h0,        32'h0,        NOP,          0, 0, 0,  0);
    step("seq_a",        1, 0, 0, 32'h0,        32'h4,        32'h0,        32'h1000_0000, 1, 0, 1, 0);
    step("seq_b",        1, 0, 0, 32'h0,        32'h8,        32'h4,        32'h1000_0004, 1, 0, 2, 0);
    step("stall1",       1, 1, 0, 32'h0,        32'h8,        32'h4,        32'h1000_0004, 1, 0, 2, 1);
    step("stall2",       1, 1, 0, 32'h0,        32'h8,        32'h4,        32'h1000_0004, 1, 0, 2, 1);
    step("stall3",       1, 1, 0, 32'h0,        32'h8,        32'h4,        32'h1000_0004, 1, 0, 2, 1);
    step("seq_c",        1, 0, 0, 32'h0,        32'hC,        32'h8,        32'h1000_0008, 1, 0, 3, 0);
    step("seq_d",        1, 0, 0, 32'h0,        32'h10,       32'hC,        32'h1000_000C, 1, 0, 4, 0);
    step("br_40",        1, 0, 1, 32'h40,       32'h40,       32'hC,        NOP,          0, 0, 4,  0);
    step("tgt_40",       1, 0, 0, 32'h0,        32'h44,       32'h40,       32'h1000_0040, 1, 0, 5, 0);
    step("br_stall_20",  1, 1, 1, 32'h20,       32'h20,       32'h40,       NOP,          0, 0, 5,  0);
    step("tgt_20",       1, 0, 0, 32'h0,        32'h24,       32'h20,       32'h1000_0020, 1, 0, 6, 0);
    step("br_42",        1, 0, 1, 32'h42,       32'h40,       32'h20,       NOP,          0, 1, 6,  0);
    step("mis_clear",    1, 0, 0, 32'h0,        32'h44,       32'h40,       32'h1000_0040, 1, 0, 7, 0);
    step("br_top",       1, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h40,     NOP,          0, 0, 7,  0);
    step("pc_wrap",      1, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0FFF_FFFC, 1, 0, 8, 0);
    step("br_80",        1, 0, 1, 32'h80,       32'h80,       32'hFFFF_FFFC, NOP,         0, 0, 8,  0);
    step("rebr_100",     1, 0, 1, 32'h100,      32'h100,      32'hFFFF_FFFC, NOP,         0, 0, 8,  0);
    step("tgt_100",      1, 0, 0, 32'h0,        32'h104,      32'h100,      32'h1000_0100, 1, 0, 9, 0);
    step("hold",         1, 1, 0, 32'h0,        32'h104,      32'h100,      32'h1000_0100, 1, 0, 9, 1);
    step("hold_br_200",  1, 1, 1, 32'h200,      32'h200,      32'h100,      NOP,          0, 0, 9,  0);
    step("tgt_200",      1, 0, 0, 32'h0,        32'h204,      32'h200,      32'h1000_0200, 1, 0, 10, 0);
    step("br_301",       1, 0, 1, 32'h301,      32'h300,      32'h200,      NOP,          0, 1, 10, 0);
    step("rst_redirect", 0, 1, 1, 32'h400,      32'h0,        32'h0,        NOP,          0, 0, 0,  0);
    step("boot_br_80",   1, 0, 1, 32'h80,       32'h80,       32'h0,        NOP,          0, 0, 0,  0);
    step("tgt_80",       1, 0, 0, 32'h0,        32'h84,       32'h80,       32'h1000_0080, 1, 0, 1, 0);
    step("hold_rst_a",   1, 1, 0, 32'h0,        32'h84,       32'h80,       32'h1000_0080, 1, 0, 1, 1);
    step("rst_hold",     0, 1, 0, 32'h0,        32'h0,        32'h0,        NOP,          0, 0, 0,  1);
    step("boot2",        1, 0, 0, 32'h0,        32'h0,        32'h0,        NOP,          0, 0, 0,  0);
    step("seq2_a",       1, 0, 0, 32'h0,        32'h4,        32'h0,        32'h1000_0000, 1, 0, 1, 0);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    repeat (2) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
